scroll_char_buffer: RTL and testbench

Parametrised character RAM for the VT52 display path. Replaces the fixed 16x64 buffer with a COLS x ROWS buffer addressed by (row, col).
- Hardware scroll: a circular top-row offset plus a fill engine that blanks rows, so scrolling never copies memory.
- The terminal core writes characters and issues scroll/clear commands; the video generator reads through an independent read port.

---
 rtl/vt52_pkg.sv | 19 +
 rtl/scroll_char_buffer_if.sv | 36 +++
 rtl/char_ram_1w1r.sv | 25 ++
 rtl/scroll_char_buffer.sv | 152 +++++++++++++++
 tb/tb_scroll_char_buffer.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vt52_pkg.sv
// Shared definitions for the VT52 display path: command encodings, fill
// character and the index-width helper used to size row/column fields.
package vt52_pkg;

    typedef enum logic [1:0] {
        CMD_NOP          = 2'd0,
        CMD_SCROLL_UP    = 2'd1,
        CMD_CLEAR_ROW    = 2'd2,
        CMD_CLEAR_SCREEN = 2'd3
    } cmd_op_e;

    localparam logic [7:0] BLANK_DEF = 8'h20;

    // Index width for n entries; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/scroll_char_buffer_if.sv
// Terminal-core / video-generator bus of the scrolling character buffer.
// master = terminal core + video reader, slave = the buffer itself.
interface scroll_char_buffer_if #(
    parameter int ROW_W  = 4,
    parameter int COL_W  = 6,
    parameter int DATA_W = 8
);
    import vt52_pkg::*;

    logic              wr_en;
    logic [ROW_W-1:0]  wr_row;
    logic [COL_W-1:0]  wr_col;
    logic [DATA_W-1:0] wr_data;
    logic [ROW_W-1:0]  rd_row;
    logic [COL_W-1:0]  rd_col;
    logic [DATA_W-1:0] rd_data;
    logic              cmd_valid;
    cmd_op_e           cmd_op;
    logic [ROW_W-1:0]  cmd_row;
    logic              cmd_ready;
    logic              busy;
    logic [ROW_W-1:0]  top_row;

    modport master (
        output wr_en, wr_row, wr_col, wr_data, rd_row, rd_col,
               cmd_valid, cmd_op, cmd_row,
        input  rd_data, cmd_ready, busy, top_row
    );

    modport slave (
        input  wr_en, wr_row, wr_col, wr_data, rd_row, rd_col,
               cmd_valid, cmd_op, cmd_row,
        output rd_data, cmd_ready, busy, top_row
    );

endinterface

// File: rtl/char_ram_1w1r.sv
// Simple dual-port character RAM: one write port, one registered read port.
// Read-first on address collision so it maps onto standard block RAM.
module char_ram_1w1r #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/scroll_char_buffer.sv
// COLS x ROWS character buffer with circular top-row offset; scrolling and
// clearing are done by a blanking fill engine instead of moving memory.
module scroll_char_buffer
    import vt52_pkg::*;
#(
    parameter int                COLS   = 64,
    parameter int                ROWS   = 16,
    parameter int                DATA_W = 8,
    parameter logic [DATA_W-1:0] BLANK  = DATA_W'(BLANK_DEF)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    scroll_char_buffer_if.slave  bus
);

    localparam int ROW_W  = idx_w(ROWS);
    localparam int COL_W  = idx_w(COLS);
    localparam int ADDR_W = ROW_W + COL_W;

    localparam logic [ROW_W:0]   ROWS_EXT = (ROW_W + 1)'(ROWS);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

    typedef enum logic {IDLE, FILL} state_e;

    state_e            state_q;
    logic [ROW_W-1:0]  top_row_q, fill_row_q, fill_last_row_q;
    logic [COL_W-1:0]  fill_col_q;
    logic              busy_q;

    logic              rd_oob_d, rd_oob_q;
    logic              rd_vld_d, rd_vld_q;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr, ram_raddr;
    logic [DATA_W-1:0] ram_wdata, ram_rdata;
    logic              cmd_acc;

    function automatic logic in_range(input logic [ROW_W-1:0] r);
        return {1'b0, r} < ROWS_EXT;
    endfunction

    // Logical -> physical row: one compare-subtract on an (ROW_W+1)-bit sum.
    function automatic logic [ROW_W-1:0] map_row(input logic [ROW_W-1:0] r,
                                                 input logic [ROW_W-1:0] top);
        logic [ROW_W:0] sum;
        sum = {1'b0, r} + {1'b0, top};
        if (sum >= ROWS_EXT) sum = sum - ROWS_EXT;
        return sum[ROW_W-1:0];
    endfunction

    assign cmd_acc = bus.cmd_valid & ~busy_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            busy_q          <= 1'b0;
            top_row_q       <= '0;
            fill_row_q      <= '0;
            fill_last_row_q <= '0;
            fill_col_q      <= '0;
        end else begin
            case (state_q)
                IDLE: if (cmd_acc) begin
                    case (bus.cmd_op)
                        CMD_SCROLL_UP: begin
                            // The old top line is recycled as the new bottom line.
                            fill_row_q      <= top_row_q;
                            fill_last_row_q <= top_row_q;
                            top_row_q       <= (top_row_q == LAST_ROW) ? '0 : top_row_q + 1'b1;
                            fill_col_q      <= '0;
                            state_q         <= FILL;
                            busy_q          <= 1'b1;
                        end
                        CMD_CLEAR_ROW: if (in_range(bus.cmd_row)) begin
                            fill_row_q      <= map_row(bus.cmd_row, top_row_q);
                            fill_last_row_q <= map_row(bus.cmd_row, top_row_q);
                            fill_col_q      <= '0;
                            state_q         <= FILL;
                            busy_q          <= 1'b1;
                        end
                        CMD_CLEAR_SCREEN: begin
                            top_row_q       <= '0;
                            fill_row_q      <= '0;
                            fill_last_row_q <= LAST_ROW;
                            fill_col_q      <= '0;
                            state_q         <= FILL;
                            busy_q          <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                FILL: begin
                    fill_col_q <= fill_col_q + 1'b1;
                    if (fill_col_q == LAST_COL) begin
                        fill_col_q <= '0;
                        if (fill_row_q == fill_last_row_q) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            fill_row_q <= fill_row_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // The fill engine owns the write port while busy; core writes are dropped.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = {map_row(bus.wr_row, top_row_q), bus.wr_col};
        ram_wdata = bus.wr_data;
        if (busy_q) begin
            ram_we    = 1'b1;
            ram_waddr = {fill_row_q, fill_col_q};
            ram_wdata = BLANK;
        end else begin
            ram_we    = bus.wr_en & in_range(bus.wr_row);
        end
        ram_raddr = {map_row(bus.rd_row, top_row_q), bus.rd_col};
        rd_oob_d  = ~in_range(bus.rd_row);
        rd_vld_d  = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_oob_q <= 1'b0;
            rd_vld_q <= 1'b0;
        end else begin
            rd_oob_q <= rd_oob_d;
            rd_vld_q <= rd_vld_d;
        end
    end

    char_ram_1w1r #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    // rd_vld_q forces zero until the first post-reset sample, since RAM isn't reset.
    assign bus.rd_data   = !rd_vld_q ? '0 : (rd_oob_q ? BLANK : ram_rdata);
    assign bus.cmd_ready = ~busy_q;
    assign bus.busy      = busy_q;
    assign bus.top_row   = top_row_q;

endmodule

// File: tb/tb_scroll_char_buffer.sv
// Directed bench: a 64x16 buffer for the main features and a 4x6 buffer for
// out-of-range rows (not representable when ROWS is a power of two).
module tb_scroll_char_buffer;
    import vt52_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    scroll_char_buffer_if #(.ROW_W(4), .COL_W(6), .DATA_W(8)) b1();
    scroll_char_buffer_if #(.ROW_W(3), .COL_W(2), .DATA_W(8)) b2();

    scroll_char_buffer #(.COLS(64), .ROWS(16), .DATA_W(8), .BLANK(8'h20)) dut (
        .clk(clk), .reset_n(reset_n), .bus(b1));
    scroll_char_buffer #(.COLS(4), .ROWS(6), .DATA_W(8), .BLANK(8'h20)) dut_s (
        .clk(clk), .reset_n(reset_n), .bus(b2));

    // ---------------- drivers for the 64x16 instance ----------------
    task automatic wr1(input logic [3:0] r, input logic [5:0] c, input logic [7:0] d);
        @(negedge clk); b1.wr_en = 1'b1; b1.wr_row = r; b1.wr_col = c; b1.wr_data = d;
        @(posedge clk); #1 b1.wr_en = 1'b0;
    endtask

    task automatic rd1(input logic [3:0] r, input logic [5:0] c, output logic [7:0] d);
        @(negedge clk); b1.rd_row = r; b1.rd_col = c;
        @(posedge clk); @(negedge clk); d = b1.rd_data;
    endtask

    task automatic cmd1(input cmd_op_e op, input logic [3:0] r);
        @(negedge clk); b1.cmd_valid = 1'b1; b1.cmd_op = op; b1.cmd_row = r;
        @(posedge clk); #1 b1.cmd_valid = 1'b0; b1.cmd_op = CMD_NOP;
    endtask

    task automatic idle1(output int n);
        n = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!b1.busy) break;
            n++;
        end
    endtask

    task automatic count_nonblank1(output int bad);
        logic [7:0] d;
        bad = 0;
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 64; c++) begin
                rd1(r[3:0], c[5:0], d);
                if (d !== 8'h20) bad++;
            end
    endtask

    // ---------------- drivers for the 4x6 instance ----------------
    task automatic wr2(input logic [2:0] r, input logic [1:0] c, input logic [7:0] d);
        @(negedge clk); b2.wr_en = 1'b1; b2.wr_row = r; b2.wr_col = c; b2.wr_data = d;
        @(posedge clk); #1 b2.wr_en = 1'b0;
    endtask

    task automatic rd2(input logic [2:0] r, input logic [1:0] c, output logic [7:0] d);
        @(negedge clk); b2.rd_row = r; b2.rd_col = c;
        @(posedge clk); @(negedge clk); d = b2.rd_data;
    endtask

    task automatic cmd2(input cmd_op_e op, input logic [2:0] r);
        @(negedge clk); b2.cmd_valid = 1'b1; b2.cmd_op = op; b2.cmd_row = r;
        @(posedge clk); #1 b2.cmd_valid = 1'b0; b2.cmd_op = CMD_NOP;
    endtask

    task automatic idle2(output int n);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!b2.busy) break;
            n++;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        repeat (3) @(negedge clk);
        vectors++; if (b1.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", b1.busy); end
        vectors++; if (b1.cmd_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", b1.cmd_ready); end
        vectors++; if (b1.top_row !== 4'd0) begin miscompares++; $display("FAIL reset_top: got %0d want 0", b1.top_row); end
        vectors++; if (b1.rd_data !== 8'h00) begin miscompares++; $display("FAIL reset_rd: got %h want 00", b1.rd_data); end
        vectors++; if (b2.busy !== 1'b0 || b2.top_row !== 3'd0) begin miscompares++; $display("FAIL reset_small: got busy %b top %0d want 0 0", b2.busy, b2.top_row); end
        reset_n = 1'b1;
    endtask

    task automatic test_write_read;
        logic [7:0] d;
        wr1(4'd0, 6'd0, 8'h41);
        wr1(4'd15, 6'd63, 8'h5A);
        rd1(4'd0, 6'd0, d);
        vectors++; if (d !== 8'h41) begin miscompares++; $display("FAIL rd_0_0: got %h want 41", d); end
        rd1(4'd15, 6'd63, d);
        vectors++; if (d !== 8'h5A) begin miscompares++; $display("FAIL rd_15_63: got %h want 5a", d); end
        // same-address read and write in one cycle
        @(negedge clk); b1.wr_en = 1'b1; b1.wr_row = 4'd0; b1.wr_col = 6'd0; b1.wr_data = 8'h42;
        b1.rd_row = 4'd0; b1.rd_col = 6'd0;
        @(posedge clk); #1 b1.wr_en = 1'b0;
        @(negedge clk);
        vectors++; if (b1.rd_data !== 8'h41) begin miscompares++; $display("FAIL read_first: got %h want 41", b1.rd_data); end
        rd1(4'd0, 6'd0, d);
        vectors++; if (d !== 8'h42) begin miscompares++; $display("FAIL after_collide: got %h want 42", d); end
    endtask

    task automatic test_scroll;
        logic [7:0] d;
        int n, bad;
        wr1(4'd1, 6'd0, 8'h31);
        cmd1(CMD_SCROLL_UP, 4'd0);
        vectors++; if (b1.top_row !== 4'd1) begin miscompares++; $display("FAIL scroll_top: got %0d want 1", b1.top_row); end
        vectors++; if (b1.busy !== 1'b1) begin miscompares++; $display("FAIL scroll_busy_rise: got %b want 1", b1.busy); end
        idle1(n);
        vectors++; if (n != 64) begin miscompares++; $display("FAIL scroll_len: got %0d want 64", n); end
        rd1(4'd0, 6'd0, d);
        vectors++; if (d !== 8'h31) begin miscompares++; $display("FAIL scroll_row0: got %h want 31", d); end
        bad = 0;
        for (int c = 0; c < 64; c++) begin rd1(4'd15, c[5:0], d); if (d !== 8'h20) bad++; end
        vectors++; if (bad != 0) begin miscompares++; $display("FAIL scroll_row15_blank: got %0d nonblank want 0", bad); end
    endtask

    task automatic test_cmd_with_write;
        logic [7:0] d;
        int n;
        // top_row=1: the write lands on physical row 3, logical row 1 after the scroll
        @(negedge clk);
        b1.cmd_valid = 1'b1; b1.cmd_op = CMD_SCROLL_UP; b1.cmd_row = 4'd0;
        b1.wr_en = 1'b1; b1.wr_row = 4'd2; b1.wr_col = 6'd5; b1.wr_data = 8'h99;
        @(posedge clk); #1 b1.cmd_valid = 1'b0; b1.cmd_op = CMD_NOP; b1.wr_en = 1'b0;
        vectors++; if (b1.top_row !== 4'd2) begin miscompares++; $display("FAIL both_top: got %0d want 2", b1.top_row); end
        idle1(n);
        vectors++; if (n != 64) begin miscompares++; $display("FAIL both_len: got %0d want 64", n); end
        rd1(4'd1, 6'd5, d);
        vectors++; if (d !== 8'h99) begin miscompares++; $display("FAIL both_data: got %h want 99", d); end
    endtask

    task automatic test_scroll_wrap;
        int n, bad, e;
        for (int k = 0; k < 16; k++) begin
            cmd1(CMD_SCROLL_UP, 4'd0);
            e = (3 + k) % 16;
            vectors++; if (b1.top_row !== e[3:0]) begin miscompares++; $display("FAIL wrap_top_%0d: got %0d want %0d", k, b1.top_row, e); end
            idle1(n);
            vectors++; if (n != 64) begin miscompares++; $display("FAIL wrap_len_%0d: got %0d want 64", k, n); end
        end
        count_nonblank1(bad);
        vectors++; if (bad != 0) begin miscompares++; $display("FAIL wrap_all_blank: got %0d nonblank want 0", bad); end
    endtask

    task automatic test_clear_screen;
        logic [7:0] d;
        int n, bad;
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 64; c++)
                wr1(r[3:0], c[5:0], {1'b1, r[3:0], c[2:0]} ^ 8'($urandom_range(0, 63)));
        cmd1(CMD_CLEAR_SCREEN, 4'd0);
        vectors++; if (b1.top_row !== 4'd0) begin miscompares++; $display("FAIL cls_top: got %0d want 0", b1.top_row); end
        @(negedge clk);
        vectors++; if (b1.cmd_ready !== 1'b0) begin miscompares++; $display("FAIL cls_ready: got %b want 0", b1.cmd_ready); end
        b1.wr_en = 1'b1; b1.wr_row = 4'd3; b1.wr_col = 6'd3; b1.wr_data = 8'h55;
        @(posedge clk); #1 b1.wr_en = 1'b0;
        idle1(n);
        vectors++; if (n + 1 != 1024) begin miscompares++; $display("FAIL cls_len: got %0d want 1024", n + 1); end
        rd1(4'd3, 6'd3, d);
        vectors++; if (d !== 8'h20) begin miscompares++; $display("FAIL cls_drop_write: got %h want 20", d); end
        count_nonblank1(bad);
        vectors++; if (bad != 0) begin miscompares++; $display("FAIL cls_all_blank: got %0d nonblank want 0", bad); end
    endtask

    task automatic test_clear_row;
        logic [7:0] d, e;
        int n, bad;
        for (int k = 0; k < 3; k++) begin cmd1(CMD_SCROLL_UP, 4'd0); idle1(n); end
        vectors++; if (b1.top_row !== 4'd3) begin miscompares++; $display("FAIL crow_top: got %0d want 3", b1.top_row); end
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 64; c++)
                wr1(r[3:0], c[5:0], {1'b1, r[3:0], c[2:0]});
        cmd1(CMD_CLEAR_ROW, 4'd5);
        idle1(n);
        vectors++; if (n != 64) begin miscompares++; $display("FAIL crow_len: got %0d want 64", n); end
        bad = 0;
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 64; c++) begin
                rd1(r[3:0], c[5:0], d);
                e = (r == 5) ? 8'h20 : {1'b1, r[3:0], c[2:0]};
                if (d !== e) bad++;
            end
        vectors++; if (bad != 0) begin miscompares++; $display("FAIL crow_cells: got %0d wrong cells want 0", bad); end
    endtask

    task automatic test_small_bounds;
        logic [7:0] d;
        int n, e;
        wr2(3'd1, 2'd0, 8'h11);
        wr2(3'd7, 2'd0, 8'h77);
        rd2(3'd1, 2'd0, d);
        vectors++; if (d !== 8'h11) begin miscompares++; $display("FAIL oob_write_dropped: got %h want 11", d); end
        rd2(3'd7, 2'd2, d);
        vectors++; if (d !== 8'h20) begin miscompares++; $display("FAIL oob_read_blank: got %h want 20", d); end
        cmd2(CMD_NOP, 3'd0);
        vectors++; if (b2.busy !== 1'b0 || b2.top_row !== 3'd0) begin miscompares++; $display("FAIL nop: got busy %b top %0d want 0 0", b2.busy, b2.top_row); end
        cmd2(CMD_CLEAR_ROW, 3'd7);
        idle2(n);
        vectors++; if (n != 0) begin miscompares++; $display("FAIL oob_clear_busy: got %0d busy cycles want 0", n); end
        rd2(3'd1, 2'd0, d);
        vectors++; if (d !== 8'h11) begin miscompares++; $display("FAIL oob_clear_noeffect: got %h want 11", d); end
        for (int k = 0; k < 6; k++) begin
            cmd2(CMD_SCROLL_UP, 3'd0);
            e = (k + 1) % 6;
            vectors++; if (b2.top_row !== e[2:0]) begin miscompares++; $display("FAIL small_top_%0d: got %0d want %0d", k, b2.top_row, e); end
            idle2(n);
            vectors++; if (n != 4) begin miscompares++; $display("FAIL small_len_%0d: got %0d want 4", k, n); end
        end
    endtask

    task automatic test_reset_mid_fill;
        int n;
        cmd1(CMD_CLEAR_SCREEN, 4'd0);
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        #1;
        vectors++; if (b1.busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy: got %b want 0", b1.busy); end
        vectors++; if (b1.cmd_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_ready: got %b want 1", b1.cmd_ready); end
        vectors++; if (b1.top_row !== 4'd0) begin miscompares++; $display("FAIL midrst_top: got %0d want 0", b1.top_row); end
        vectors++; if (b1.rd_data !== 8'h00) begin miscompares++; $display("FAIL midrst_rd: got %h want 00", b1.rd_data); end
        @(negedge clk);
        reset_n = 1'b1;
        b1.cmd_valid = 1'b1; b1.cmd_op = CMD_SCROLL_UP; b1.cmd_row = 4'd0;
        @(posedge clk); #1 b1.cmd_valid = 1'b0; b1.cmd_op = CMD_NOP;
        vectors++; if (b1.busy !== 1'b1 || b1.top_row !== 4'd1) begin miscompares++; $display("FAIL postrst_accept: got busy %b top %0d want 1 1", b1.busy, b1.top_row); end
        idle1(n);
        vectors++; if (n != 64) begin miscompares++; $display("FAIL postrst_len: got %0d want 64", n); end
    endtask

    initial begin
        b1.wr_en = 1'b0; b1.wr_row = '0; b1.wr_col = '0; b1.wr_data = '0;
        b1.rd_row = '0; b1.rd_col = '0; b1.cmd_valid = 1'b0; b1.cmd_op = CMD_NOP; b1.cmd_row = '0;
        b2.wr_en = 1'b0; b2.wr_row = '0; b2.wr_col = '0; b2.wr_data = '0;
        b2.rd_row = '0; b2.rd_col = '0; b2.cmd_valid = 1'b0; b2.cmd_op = CMD_NOP; b2.cmd_row = '0;
        test_reset();
        test_write_read();
        test_scroll();
        test_cmd_with_write();
        test_scroll_wrap();
        test_clear_screen();
        test_clear_row();
        test_small_bounds();
        test_reset_mid_fill();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
